// File: rtl/exp_prescale.sv
// exp_prescale: multiplies a float operand by log2(e) so a downstream 2^y stage produces e^x.
// 3-stage valid/ready pipeline; define EXP_PRESCALE_RNE_EN for round-to-nearest-even, else truncate.
module exp_prescale #(
    parameter int          WIDTH = 18,
    parameter logic [15:0] LOG2E = 16'hB8AA
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    localparam int         MW      = WIDTH - 9;
    localparam int         PW      = MW + 17;
    localparam logic [7:0] EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        CLS_NORM = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_SPEC = 2'd2
    } cls_e;

    logic s1_valid_q, s2_valid_q, s3_valid_q;
    logic s1_load, s2_load, s3_load;

    // A stage may load whenever the stage after it can take its current word.
    assign s3_load   = !s3_valid_q || out_ready;
    assign s2_load   = !s2_valid_q || s3_load;
    assign s1_load   = !s1_valid_q || s2_load;
    assign in_ready  = s1_load;
    assign out_valid = s3_valid_q;

    logic          in_sign;
    logic [7:0]    in_exp;
    logic [MW-1:0] in_man;
    cls_e          in_cls;

    always_comb begin
        in_sign = in_data[WIDTH-1];
        in_exp  = in_data[WIDTH-2 -: 8];
        in_man  = in_data[MW-1:0];
        if (in_exp == 8'd0) begin
            in_cls = CLS_ZERO;
        end else if (in_exp == EXP_MAX) begin
            in_cls = CLS_SPEC;
        end else begin
            in_cls = CLS_NORM;
        end
    end

    logic          s1_sign_q;
    logic [7:0]    s1_exp_q;
    logic [MW-1:0] s1_man_q;
    cls_e          s1_cls_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_exp_q   <= 8'd0;
            s1_man_q   <= '0;
            s1_cls_q   <= CLS_NORM;
        end else if (s1_load) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_sign_q <= in_sign;
                s1_exp_q  <= in_exp;
                s1_man_q  <= in_man;
                s1_cls_q  <= in_cls;
            end
        end
    end

    logic [PW-1:0] s1_prod;
    assign s1_prod = PW'({1'b1, s1_man_q}) * PW'(LOG2E);

    logic          s2_sign_q;
    logic [7:0]    s2_exp_q;
    logic [MW-1:0] s2_man_q;
    cls_e          s2_cls_q;
    logic [PW-1:0] s2_prod_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_exp_q   <= 8'd0;
            s2_man_q   <= '0;
            s2_cls_q   <= CLS_NORM;
            s2_prod_q  <= '0;
        end else if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_sign_q <= s1_sign_q;
                s2_exp_q  <= s1_exp_q;
                s2_man_q  <= s1_man_q;
                s2_cls_q  <= s1_cls_q;
                s2_prod_q <= s1_prod;
            end
        end
    end

    logic             shift;
    logic [MW-1:0]    mant_t;
    logic             guard;
    logic             sticky;
    logic [9:0]       exp_n;
    logic [MW-1:0]    mant_r;
    logic [9:0]       exp_r;
    logic [WIDTH-1:0] res;
`ifdef EXP_PRESCALE_RNE_EN
    logic             round_up;
    logic             carry;
`else
    logic             unused_rnd_bits;
    assign unused_rnd_bits = guard ^ sticky;
`endif

    // Product lies in [1,4): bit PW-1 is the 2's place, so a set top bit means shift right by one.
    always_comb begin
        shift = s2_prod_q[PW-1];
        if (shift) begin
            mant_t = s2_prod_q[PW-2 -: MW];
            guard  = s2_prod_q[PW-2-MW];
            sticky = |s2_prod_q[PW-3-MW:0];
        end else begin
            mant_t = s2_prod_q[PW-3 -: MW];
            guard  = s2_prod_q[PW-3-MW];
            sticky = |s2_prod_q[PW-4-MW:0];
        end
        exp_n = {2'b00, s2_exp_q} + {9'd0, shift};
`ifdef EXP_PRESCALE_RNE_EN
        round_up        = guard && (sticky || mant_t[0]);
        {carry, mant_r} = {1'b0, mant_t} + {{MW{1'b0}}, round_up};
        exp_r           = exp_n + {9'd0, carry};
`else
        mant_r = mant_t;
        exp_r  = exp_n;
`endif
        case (s2_cls_q)
            CLS_ZERO: res = {s2_sign_q, {(WIDTH-1){1'b0}}};
            CLS_SPEC: res = {s2_sign_q, EXP_MAX, s2_man_q};
            default: begin
                if (exp_r >= 10'd255) begin
                    res = {s2_sign_q, EXP_MAX, {MW{1'b0}}};
                end else begin
                    res = {s2_sign_q, exp_r[7:0], mant_r};
                end
            end
        endcase
    end

    logic [WIDTH-1:0] out_data_q;
    assign out_data = out_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid_q <= 1'b0;
            out_data_q <= '0;
        end else if (s3_load) begin
            s3_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                out_data_q <= res;
            end
        end
    end

endmodule

// File: tb/tb_exp_prescale.sv
// tb_exp_prescale: directed bench for exp_prescale with an arithmetic reference model and scoreboard.
// Honours EXP_PRESCALE_RNE_EN the same way as the design.
module tb_exp_prescale;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_data;

    exp_prescale dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial forever #5 clk = ~clk;

`ifdef EXP_PRESCALE_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    int          n_out = 0;
    logic [17:0] sb[$];
    logic        pat_en = 1'b0;
    logic        ready_force = 1'b1;

    // Reference: real-valued product of the significands, scaled to integers.
    function automatic logic [17:0] model(input logic [17:0] x);
        logic   s;
        int     e;
        longint m, p, scale, q, r;
        s = x[17];
        e = int'(x[16:9]);
        m = longint'(x[8:0]);
        if (e == 0) return {s, 17'd0};
        if (e == 255) return x;
        p = (512 + m) * 47274;
        if (p >= 33554432) begin
            scale = 65536;
            e = e + 1;
        end else begin
            scale = 32768;
        end
        q = p / scale;
        r = p % scale;
        if (RNE) begin
            if ((r * 2 > scale) || ((r * 2 == scale) && (q % 2 == 1))) q = q + 1;
            if (q == 1024) begin
                q = 512;
                e = e + 1;
            end
        end
        if (e >= 255) return {s, 8'hFF, 9'd0};
        return {s, 8'(e), 9'(q - 512)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic        stall_q = 1'b0;
        logic [17:0] held = '0;
        logic [17:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                stall_q = 1'b0;
                chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
                chk("rst_out_data", {14'd0, out_data}, 32'd0);
            end else begin
                chk("in_ready", {31'd0, in_ready}, {31'd0, !(sb.size() == 3 && !out_ready)});
                if (stall_q) begin
                    chk("hold_valid", {31'd0, out_valid}, 32'd1);
                    chk("hold_data", {14'd0, out_data}, {14'd0, held});
                end
                if (out_valid && out_ready) begin
                    n_out++;
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL spurious_out: got 0x%0h expected no word", out_data);
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", {14'd0, out_data}, {14'd0, e});
                    end
                end
                stall_q = out_valid && !out_ready;
                held    = out_data;
                if (in_valid && in_ready) sb.push_back(model(in_data));
            end
        end
    endtask

    int pidx = 0;
    task automatic ready_drv();
        forever begin
            @(posedge clk);
            #1;
            if (pat_en) begin
                out_ready = (pidx == 0 || pidx == 3);
                pidx = (pidx + 1) % 4;
            end else begin
                out_ready = ready_force;
                pidx = 0;
            end
        end
    endtask

    // Called just after a rising edge; returns just after the edge that took the word.
    task automatic send(input logic [17:0] d);
        int t;
        in_valid = 1'b1;
        in_data  = d;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: got in_ready 0 expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_one(input string name, input logic [17:0] d, input logic [17:0] lit);
        int lat;
        send(d);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        chk({name, "_lat"}, 32'(lat), 32'd3);
        chk(name, {14'd0, out_data}, {14'd0, lit});
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    logic [17:0] vin[10];
    logic [17:0] vrne[10];
    logic [17:0] vtrn[10];
    logic [17:0] strm[8];

    initial begin
        int base;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        out_ready = 1'b1;
        vin[0] = 18'h0FE00; vrne[0] = 18'h0FEE3; vtrn[0] = 18'h0FEE2;
        vin[1] = 18'h30000; vrne[1] = 18'h300E3; vtrn[1] = 18'h300E2;
        vin[2] = 18'h1FDFF; vrne[2] = 18'h1FE00; vtrn[2] = 18'h1FE00;
        vin[3] = 18'h1FE05; vrne[3] = 18'h1FE05; vtrn[3] = 18'h1FE05;
        vin[4] = 18'h20000; vrne[4] = 18'h20000; vtrn[4] = 18'h20000;
        vin[5] = 18'h00123; vrne[5] = 18'h00000; vtrn[5] = 18'h00000;
        vin[6] = 18'h3FE00; vrne[6] = 18'h3FE00; vtrn[6] = 18'h3FE00;
        vin[7] = 18'h0FF00; vrne[7] = 18'h1002A; vtrn[7] = 18'h10029;
        vin[8] = 18'h1FBFF; vrne[8] = 18'h1FCE2; vtrn[8] = 18'h1FCE1;
        vin[9] = 18'h00200; vrne[9] = 18'h002E3; vtrn[9] = 18'h002E2;
        strm[0] = 18'h0FE00; strm[1] = 18'h30000; strm[2] = 18'h0FF00; strm[3] = 18'h1FDFF;
        strm[4] = 18'h1FE05; strm[5] = 18'h00123; strm[6] = 18'h10400; strm[7] = 18'h2F555;

        fork
            monitor();
            ready_drv();
        join_none

        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 10; i++) begin
            expect_one($sformatf("vec%0d", i), vin[i], RNE ? vrne[i] : vtrn[i]);
        end

        // Back-to-back stream under the 1,0,0,1 ready pattern.
        base = n_out;
        pat_en = 1'b1;
        for (int i = 0; i < 8; i++) send(strm[i]);
        drain();
        pat_en = 1'b0;
        chk("stream_count", 32'(n_out - base), 32'd8);

        // Full stall: three words fill the pipe and in_ready must fall.
        ready_force = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) send(vin[i + 7]);
        @(negedge clk);
        chk("full_stall_ready", {31'd0, in_ready}, 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        ready_force = 1'b1;
        drain();

        // Reset with three words in flight.
        ready_force = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) send(strm[i]);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_data", {14'd0, out_data}, 32'd0);
        ready_force = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        expect_one("post_reset", 18'h30000, RNE ? 18'h300E3 : 18'h300E2);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
